// File: rtl/if_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_pkg
// Shared CPU definitions used by the instruction-fetch stage and its IF/ID
// register: the canonical NOP encoding, the fetch FSM state type, the bit-field
// positions the control decoder slices out of an instruction word, and a small
// PC alignment helper.
// -----------------------------------------------------------------------------
package if_stage_pkg;

    // addi x0, x0, 0 -- what a bubble looks like to the decoder
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Control-decoder field positions inside an instruction word
    localparam int unsigned OPCODE_MSB = 6;
    localparam int unsigned OPCODE_LSB = 2;
    localparam int unsigned F3_MSB     = 14;
    localparam int unsigned F3_LSB     = 12;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT_ID,
        DISCARD
    } fetch_state_e;

    // Fetch addresses are word aligned; low two bits of any target are dropped
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// -----------------------------------------------------------------------------
// ifid_reg
// IF/ID pipeline register with flush and hold. Flush wins over load; with
// neither asserted the register holds (decode stall).
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   i_flush  : replace contents with a bubble (valid=0, instr=NOP)
//   i_load   : capture i_pc / i_instr as a valid instruction
//   i_pc     : PC to capture
//   i_instr  : instruction word to capture
//   o_valid  : register holds a real instruction
//   o_pc     : PC of held instruction
//   o_instr  : held instruction word
// -----------------------------------------------------------------------------
module ifid_reg
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_flush,
    input  logic        i_load,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr
);

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_instr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_pc    <= 32'h0000_0000;
            r_instr <= NOP_INSTR;
        end else if (i_flush) begin
            // PC is left alone: it is meaningless while valid=0
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage. Issues one outstanding word fetch at a time to the
// I-cache, delivers fetched words into the IF/ID register, absorbs a decode
// stall with a one-entry skid register, and handles branch redirects
// (including a redirect that arrives while a fetch is still outstanding).
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   icache_req   : registered fetch request
//   icache_addr  : fetch word address, stable while icache_req=1
//   icache_ready : one-cycle completion pulse, icache_rdata valid
//   icache_rdata : fetched instruction word
//   redirect     : taken branch/jump, flush and refetch at redirect_pc
//   redirect_pc  : redirect target (low two bits ignored)
//   stall        : decode cannot accept, hold IF/ID
//   ifid_valid   : IF/ID holds a real instruction
//   ifid_pc      : PC of IF/ID instruction
//   ifid_instr   : IF/ID instruction word
//   opcode       : ifid_instr[6:2]
//   f3           : ifid_instr[14:12]
// -----------------------------------------------------------------------------
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        icache_req,
    output logic [31:0] icache_addr,
    input  logic        icache_ready,
    input  logic [31:0] icache_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic [4:0]  opcode,
    output logic [2:0]  f3
);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic         r_req;
    logic [31:0]  r_addr;
    logic         r_skid_valid;
    logic [31:0]  r_skid_pc;
    logic [31:0]  r_skid_instr;

    logic [31:0]  w_pc_inc;
    logic [31:0]  w_target;
    logic         w_ifid_flush;
    logic         w_ifid_load;
    logic [31:0]  w_ifid_pc;
    logic [31:0]  w_ifid_instr;

    // Natural 32-bit overflow gives the required wrap to zero
    assign w_pc_inc = r_pc + 32'd4;
    assign w_target = align_pc(redirect_pc);

    // IF/ID control: redirect flushes regardless of stall or ready
    always_comb begin
        w_ifid_flush = 1'b0;
        w_ifid_load  = 1'b0;
        w_ifid_pc    = r_pc;
        w_ifid_instr = icache_rdata;
        if (redirect) begin
            w_ifid_flush = 1'b1;
        end else begin
            unique case (r_state)
                FETCH: begin
                    if (!stall) begin
                        w_ifid_load  = icache_ready;
                        w_ifid_flush = !icache_ready;
                    end
                end
                WAIT_ID: begin
                    if (!stall) begin
                        w_ifid_load  = r_skid_valid;
                        w_ifid_pc    = r_skid_pc;
                        w_ifid_instr = r_skid_instr;
                    end
                end
                DISCARD: begin
                    w_ifid_flush = !stall;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_req        <= 1'b0;
            r_addr       <= RESET_PC;
            r_skid_valid <= 1'b0;
            r_skid_pc    <= 32'h0000_0000;
            r_skid_instr <= NOP_INSTR;
        end else if (redirect) begin
            r_pc         <= w_target;
            r_skid_valid <= 1'b0;
            if ((r_state == FETCH || r_state == DISCARD) && !icache_ready) begin
                // Outstanding fetch must complete on its old address first
                r_state <= DISCARD;
            end else begin
                r_state <= FETCH;
                r_req   <= 1'b1;
                r_addr  <= w_target;
            end
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_state <= FETCH;
                    r_req   <= 1'b1;
                    r_addr  <= r_pc;
                end
                FETCH: begin
                    if (icache_ready) begin
                        if (stall) begin
                            r_skid_valid <= 1'b1;
                            r_skid_pc    <= r_pc;
                            r_skid_instr <= icache_rdata;
                            r_req        <= 1'b0;
                            r_state      <= WAIT_ID;
                        end else begin
                            r_pc   <= w_pc_inc;
                            r_addr <= w_pc_inc;
                        end
                    end
                end
                WAIT_ID: begin
                    if (!stall) begin
                        r_skid_valid <= 1'b0;
                        r_pc         <= w_pc_inc;
                        r_addr       <= w_pc_inc;
                        r_req        <= 1'b1;
                        r_state      <= FETCH;
                    end
                end
                DISCARD: begin
                    if (icache_ready) begin
                        r_addr  <= r_pc;
                        r_state <= FETCH;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    ifid_reg u_ifid_reg (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_ifid_flush),
        .i_load  (w_ifid_load),
        .i_pc    (w_ifid_pc),
        .i_instr (w_ifid_instr),
        .o_valid (ifid_valid),
        .o_pc    (ifid_pc),
        .o_instr (ifid_instr)
    );

    assign icache_req  = r_req;
    assign icache_addr = r_addr;
    assign opcode      = ifid_instr[OPCODE_MSB:OPCODE_LSB];
    assign f3          = ifid_instr[F3_MSB:F3_LSB];

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Directed scenarios followed by a randomized run. The I-cache is modelled as
// a memory whose word at address a is mem_word(a), answering after a random
// latency. The reference model is the architectural instruction stream: every
// delivered instruction must be the next sequential PC since the last
// redirect, carry that PC's memory word, and IF/ID must hold under stall and
// bubble on redirect.
// -----------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_ready = 1'b0;
    logic [31:0] icache_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic [4:0]  opcode;
    logic [2:0]  f3;

    int tests = 0;
    int fails = 0;

    if_stage #(
        .RESET_PC (RST_PC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .icache_req   (icache_req),
        .icache_addr  (icache_addr),
        .icache_ready (icache_ready),
        .icache_rdata (icache_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .stall        (stall),
        .ifid_valid   (ifid_valid),
        .ifid_pc      (ifid_pc),
        .ifid_instr   (ifid_instr),
        .opcode       (opcode),
        .f3           (f3)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'h5A5A_00F3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a cache response for the current address on the next edge
    task automatic respond(input logic r);
        icache_ready = r;
        icache_rdata = r ? mem_word(icache_addr) : 32'hDEAD_BEEF;
    endtask

    logic [31:0] exp_pc;
    logic [31:0] instr_v;
    logic        p_redirect, p_stall, p_req, p_ready, p_valid;
    logic [31:0] p_rpc, p_addr, p_pc, p_instr;
    int          wait_cnt;
    int          deliveries;

    initial begin
        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_req", {31'b0, icache_req}, 32'd0);
        check("rst_addr", icache_addr, RST_PC);
        check("rst_valid", {31'b0, ifid_valid}, 32'd0);
        check("rst_ifid_pc", ifid_pc, 32'd0);
        check("rst_instr", ifid_instr, NOP);
        check("rst_opcode", {27'b0, opcode}, 32'd4);
        check("rst_f3", {29'b0, f3}, 32'd0);

        // ---------------- sequential fetch ----------------
        rst = 1'b0;
        tick();
        check("seq_req0", {31'b0, icache_req}, 32'd1);
        check("seq_addr0", icache_addr, 32'h0);
        check("seq_valid0", {31'b0, ifid_valid}, 32'd0);
        respond(1'b1);
        tick();
        check("seq_addr4", icache_addr, 32'h4);
        check("seq_ifpc0", ifid_pc, 32'h0);
        check("seq_valid1", {31'b0, ifid_valid}, 32'd1);
        check("seq_instr0", ifid_instr, mem_word(32'h0));
        respond(1'b1);
        tick();
        check("seq_addr8", icache_addr, 32'h8);
        check("seq_ifpc4", ifid_pc, 32'h4);

        // ---------------- stall with data returning ----------------
        respond(1'b1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            respond(1'b0);
            check("stall_req", {31'b0, icache_req}, 32'd0);
            check("stall_ifpc", ifid_pc, 32'h4);
            check("stall_valid", {31'b0, ifid_valid}, 32'd1);
        end
        stall = 1'b0;
        tick();
        check("unstall_ifpc", ifid_pc, 32'h8);
        check("unstall_instr", ifid_instr, mem_word(32'h8));
        check("unstall_req", {31'b0, icache_req}, 32'd1);
        check("unstall_addr", icache_addr, 32'hC);
        respond(1'b1);
        tick();
        check("pre_redir_addr", icache_addr, 32'h10);

        // ---------------- redirect while fetch outstanding ----------------
        respond(1'b0);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        check("disc_addr_a", icache_addr, 32'h10);
        check("disc_req_a", {31'b0, icache_req}, 32'd1);
        check("disc_valid_a", {31'b0, ifid_valid}, 32'd0);
        tick();
        check("disc_addr_b", icache_addr, 32'h10);
        respond(1'b1);
        tick();
        check("disc_drop_valid", {31'b0, ifid_valid}, 32'd0);
        check("disc_next_addr", icache_addr, 32'h100);
        respond(1'b1);
        tick();
        check("tgt_ifpc", ifid_pc, 32'h100);
        check("tgt_instr", ifid_instr, mem_word(32'h100));

        // ---------------- redirect and stall together ----------------
        respond(1'b1);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        stall       = 1'b1;
        tick();
        check("rs_valid", {31'b0, ifid_valid}, 32'd0);
        check("rs_instr", ifid_instr, NOP);
        check("rs_opcode", {27'b0, opcode}, 32'd4);
        check("rs_f3", {29'b0, f3}, 32'd0);
        check("rs_addr", icache_addr, 32'h200);

        // ---------------- unaligned target and PC wrap ----------------
        stall       = 1'b0;
        redirect_pc = 32'hFFFF_FFFE;
        respond(1'b1);
        tick();
        redirect = 1'b0;
        check("wrap_addr_top", icache_addr, 32'hFFFF_FFFC);
        respond(1'b1);
        tick();
        check("wrap_addr_zero", icache_addr, 32'h0);
        check("wrap_ifpc", ifid_pc, 32'hFFFF_FFFC);
        respond(1'b1);
        tick();
        check("wrap_ifpc0", ifid_pc, 32'h0);

        // ---------------- asynchronous reset mid-request ----------------
        respond(1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_req", {31'b0, icache_req}, 32'd0);
        check("arst_valid", {31'b0, ifid_valid}, 32'd0);
        check("arst_addr", icache_addr, RST_PC);
        icache_ready = 1'b1;
        icache_rdata = 32'h1234_5677;
        tick();
        tick();
        check("arst_ign_valid", {31'b0, ifid_valid}, 32'd0);
        check("arst_ign_req", {31'b0, icache_req}, 32'd0);
        rst = 1'b0;
        tick();
        check("idle_ign_valid", {31'b0, ifid_valid}, 32'd0);
        check("idle_ign_instr", ifid_instr, NOP);
        check("idle_req", {31'b0, icache_req}, 32'd1);
        check("idle_addr", icache_addr, RST_PC);

        // ---------------- randomized run ----------------
        exp_pc     = RST_PC;
        wait_cnt   = -1;
        deliveries = 0;
        icache_ready = 1'b0;
        p_redirect = 1'b0;
        p_stall    = 1'b0;
        p_req      = icache_req;
        p_ready    = 1'b0;
        p_addr     = icache_addr;
        p_rpc      = 32'h0;
        p_valid    = ifid_valid;
        p_pc       = ifid_pc;
        p_instr    = ifid_instr;
        for (int cyc = 0; cyc < 500; cyc++) begin
            tick();
            if (p_redirect) begin
                check("rnd_flush_valid", {31'b0, ifid_valid}, 32'd0);
                check("rnd_flush_instr", ifid_instr, NOP);
                exp_pc = {p_rpc[31:2], 2'b00};
            end else if (p_stall) begin
                check("rnd_hold_valid", {31'b0, ifid_valid}, {31'b0, p_valid});
                check("rnd_hold_pc", ifid_pc, p_pc);
                check("rnd_hold_instr", ifid_instr, p_instr);
            end else if (ifid_valid) begin
                check("rnd_pc", ifid_pc, exp_pc);
                check("rnd_instr", ifid_instr, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                deliveries++;
            end
            if (p_req && !p_ready) begin
                check("rnd_req_held", {31'b0, icache_req}, 32'd1);
                check("rnd_addr_held", icache_addr, p_addr);
            end
            instr_v = ifid_instr;
            check("rnd_opcode", {27'b0, opcode}, {27'b0, instr_v[6:2]});
            check("rnd_f3", {29'b0, f3}, {29'b0, instr_v[14:12]});

            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 11) == 0);
            redirect_pc = $urandom;
            if (icache_req) begin
                if (wait_cnt < 0) wait_cnt = int'($urandom_range(0, 3));
                if (wait_cnt == 0) begin
                    respond(1'b1);
                    wait_cnt = -1;
                end else begin
                    respond(1'b0);
                    wait_cnt--;
                end
            end else begin
                respond(1'b0);
                wait_cnt = -1;
            end
            p_redirect = redirect;
            p_stall    = stall;
            p_rpc      = redirect_pc;
            p_req      = icache_req;
            p_ready    = icache_ready;
            p_addr     = icache_addr;
            p_valid    = ifid_valid;
            p_pc       = ifid_pc;
            p_instr    = ifid_instr;
        end
        tests++;
        assert (deliveries >= 40) else begin
            fails++;
            $error("FAIL rnd_throughput: observed %0d deliveries expected at least 40", deliveries);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
